// File: rtl/unishift_burst.sv
// Universal WIDTH-bit shift register with a counted burst-shift engine (busy/done handshake).
// Optional parity output enabled by defining UNISHIFT_PARITY_EN.
module unishift_burst #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] par_in,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
`ifdef UNISHIFT_PARITY_EN
    output logic             parity,
`endif
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHR  = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_LOAD = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_ROL  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               sout_r_q, sout_r_d;
    logic               sout_l_q, sout_l_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         mode_r_q, mode_r_d;
    logic               shift_class_c;
    logic               burst_start_c;
    logic               do_op_c;
    logic [2:0]         op_mode_c;

    assign shift_class_c = (mode == M_SHR) || (mode == M_SHL) || (mode == M_ROR) ||
                           (mode == M_ROL) || (mode == M_ASR);
    assign burst_start_c = (state_q == S_IDLE) && en && start && shift_class_c &&
                           (count != CNT_W'(0));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (burst_start_c) state_d = S_BURST;
            S_BURST: if (en && (cnt_q == CNT_W'(1))) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and handshake next values
    always_comb begin
        q_d       = q_q;
        sout_r_d  = sout_r_q;
        sout_l_d  = sout_l_q;
        cnt_d     = cnt_q;
        mode_r_d  = mode_r_q;
        do_op_c   = 1'b0;
        op_mode_c = mode;

        case (state_q)
            S_IDLE: begin
                if (burst_start_c) begin
                    cnt_d    = count;
                    mode_r_d = mode;
                end else if (en) begin
                    do_op_c = 1'b1;
                end
            end
            S_BURST: begin
                op_mode_c = mode_r_q;
                if (en) begin
                    do_op_c = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase

        if (do_op_c) begin
            case (op_mode_c)
                M_SHR: begin
                    q_d      = {sin_r, q_q[WIDTH-1:1]};
                    sout_r_d = q_q[0];
                end
                M_SHL: begin
                    q_d      = {q_q[WIDTH-2:0], sin_l};
                    sout_l_d = q_q[WIDTH-1];
                end
                M_LOAD: q_d = par_in;
                M_ROR: begin
                    q_d      = {q_q[0], q_q[WIDTH-1:1]};
                    sout_r_d = q_q[0];
                end
                M_ROL: begin
                    q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    sout_l_d = q_q[WIDTH-1];
                end
                M_ASR: begin
                    q_d      = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                    sout_r_d = q_q[0];
                end
                M_CLR:  q_d = '0;
                M_HOLD: ;
                default: ;
            endcase
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_BURST) && (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q      <= '0;
            sout_r_q <= 1'b0;
            sout_l_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            mode_r_q <= M_HOLD;
        end else begin
            q_q      <= q_d;
            sout_r_q <= sout_r_d;
            sout_l_q <= sout_l_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            mode_r_q <= mode_r_d;
        end
    end

`ifdef UNISHIFT_PARITY_EN
    logic parity_q;

    // Parity tracks q on the same edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^q_d;
        end
    end

    assign parity = parity_q;
`endif

    assign q      = q_q;
    assign sout_r = sout_r_q;
    assign sout_l = sout_l_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: doc/unishift_burst.md
Name: unishift_burst

Overview:
- Parametrised universal shift register, WIDTH bits wide.
- Supports hold, logical shift, rotate, arithmetic shift, parallel load and clear.
- Adds a burst engine that performs N back-to-back shifts from a single start request, with busy/done handshake.
- Serves as the datapath shifter for serializers and shift-based arithmetic in the design.

Parameters:
- WIDTH, 8: register width in bits (≥2).
- CNT_W, 4: width of burst count; maximum burst is 2^CNT_W-1 shifts.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  operation enable; low = freeze (IDLE and BURST).
- mode  input  3  operation select (see Behaviour).
- start  input  1  burst request, sampled in IDLE with en=1.
- count  input  CNT_W  number of shifts in the burst.
- par_in  input  WIDTH  parallel load data.
- sin_r  input  1  serial in at MSB for right shift (mode 001).
- sin_l  input  1  serial in at LSB for left shift (mode 010).
- q  output  WIDTH  register contents.
- sout_r  output  1  bit that left the LSB on the most recent right-direction op.
- sout_l  output  1  bit that left the MSB on the most recent left-direction op.
- busy  output  1  burst in progress.
- done  output  1  one-cycle burst completion pulse.

Behaviour:
- Reset (rst_n=0 at edge): q=0, sout_r=0, sout_l=0, busy=0, done=0, internal cnt=0, state=IDLE. Reset overrides everything; a reset mid-burst abandons the burst and no done is issued.
- Mode encoding:
  - 000 hold.
  - 001 logical shift right: q<={sin_r,q[W-1:1]}.
  - 010 shift left: q<={q[W-2:0],sin_l}.
  - 011 load par_in.
  - 100 rotate right.
  - 101 rotate left.
  - 110 arithmetic shift right: MSB replicated.
  - 111 clear.
- Shift-class modes: 001, 010, 100, 101, 110.
- sout_r is updated only on 001/100/110, taking the old q[0]. sout_l is updated only on 010/101, taking the old q[W-1]. Otherwise both hold.
- States: IDLE, BURST, DONE. busy = (state != IDLE), registered.
- IDLE, en=0: everything holds; start is ignored.
- IDLE, en=1, and either start=0, count=0, or mode not shift-class: one op of mode per edge, 1-cycle latency. No busy or done.
- IDLE, en=1, start=1, shift-class mode, count≠0: latch mode_r<=mode and cnt<=count; go to BURST. q is unchanged on that edge; busy=1 from that edge.
- BURST, en=1: one mode_r op per edge, cnt decrements. On the edge with cnt==1, do the final shift, go to DONE, set done=1.
- BURST, en=0: q, cnt and sout hold (pause); busy stays 1.
- While in BURST: mode, start, count and par_in are ignored. sin_r/sin_l are sampled live on each shift edge.
- DONE: lasts exactly one cycle with done=1 and q holding the final value. The next edge goes to IDLE with busy=0 and done=0, regardless of en. start in DONE is ignored.
- Burst of N shifts: busy high N+1 cycles; done high in cycle N+1 after the start edge.

Optional Feature:
- Macro UNISHIFT_PARITY_EN.
- Defined: adds output parity (1 bit) = XOR-reduce of q, registered on the same edge as q (always consistent with q); reset value 0.
- Undefined: the parity port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: load q=8'hFF, then hold rst_n=0 for one edge -> q=00, busy=0, done=0, sout_r=sout_l=0.
- Load and shift: mode 011, par_in=A5 -> q=A5. Then mode 001, sin_r=1 -> q=D2, sout_r=1.
- Rotate: q=A5, mode 101, one edge -> q=4B, sout_l=1. Then mode 100 -> q=A5, sout_r=1.
- Arithmetic burst: q=81, start=1, mode 110, count=3 -> q goes C0, E0, F0. busy high 4 cycles; done high one cycle with q=F0; sout_r=0 at end.
- Pause: q=01, start, mode 010, sin_l=0, count=4. Drop en for 2 cycles after the first shift -> q holds 02 during the pause, then 04, 08, 10. done pulses once.
- Reset mid-burst and degenerate start:
  - start with count=10; rst_n low after 3 shifts -> q=00, busy=0, no done.
  - start with count=0, mode 001 -> single shift, busy and done stay 0.
